sram_arbiter_2port: RTL and testbench

//  Two-port arbiter/sequencer for the DE2 16-bit x 256K-word async SRAM.
//  Two on-chip masters (port A, port B) issue req/ack word or byte accesses.
//  The block grants one master at a time and drives the SRAM pins directly with registered strobes.
//  It enforces setup, strobe and hold timing; no raw host strobes reach the SRAM pins.

---
 rtl/sram_arbiter_2port.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_arbiter_2port.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2port.sv
// sram_arbiter_2port: two-master req/ack arbiter and sequencer for a 16-bit
// asynchronous SRAM. One access at a time: IDLE -> SETUP -> ACCESS -> DONE.
// Every SRAM pin comes from a flop, so no host strobe reaches the SRAM directly.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port A always
// wins a tie). By default the two ports are served round-robin.
module sram_arbiter_2port #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iA_REQ,
  input  logic              iA_WE,
  input  logic [ADDR_W-1:0] iA_ADDR,
  input  logic [DATA_W-1:0] iA_DATA,
  input  logic [1:0]        iA_BE_N,
  output logic              oA_ACK,
  output logic [DATA_W-1:0] oA_DATA,
  input  logic              iB_REQ,
  input  logic              iB_WE,
  input  logic [ADDR_W-1:0] iB_ADDR,
  input  logic [DATA_W-1:0] iB_DATA,
  input  logic [1:0]        iB_BE_N,
  output logic              oB_ACK,
  output logic [DATA_W-1:0] oB_DATA,
  output logic              oBUSY,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant_b_q, grant_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_n_q, be_n_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                we_n_q, we_n_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                busy_q, busy_d;

  logic                a_win, b_win;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic                last_grant_b_q, last_grant_b_d;
`endif

  // Arbitration: requests are only looked at while IDLE
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (state_q == IDLE) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      a_win = iA_REQ;
`else
      a_win = iA_REQ && (!iB_REQ || last_grant_b_q);
`endif
      b_win = iB_REQ && !a_win;
    end
  end

`ifndef SRAM_ARB_FIXED_PRIO_EN
  // Round-robin history: remember which port was granted last
  always_comb begin
    last_grant_b_d = last_grant_b_q;
    if (a_win)      last_grant_b_d = 1'b0;
    else if (b_win) last_grant_b_d = 1'b1;
  end

  // Round-robin history register; B counts as last granted out of reset
  always_ff @(posedge iCLK) begin
    if (iRST) last_grant_b_q <= 1'b1;
    else      last_grant_b_q <= last_grant_b_d;
  end
`endif

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_win || b_win) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, strobe-width counter and read-data capture
  always_comb begin
    grant_b_d = grant_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_n_d    = be_n_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_win) begin
      grant_b_d = 1'b0;
      we_d      = iA_WE;
      addr_d    = iA_ADDR;
      wdata_d   = iA_DATA;
      be_n_d    = iA_BE_N;
    end else if (b_win) begin
      grant_b_d = 1'b1;
      we_d      = iB_WE;
      addr_d    = iB_ADDR;
      wdata_d   = iB_DATA;
      be_n_d    = iB_BE_N;
    end
    if (state_q == SETUP) begin
      cnt_d = CNT_W'(WAIT_CYCLES - 1);
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // Final ACCESS edge: OE_N has been low since SETUP, so DQ is settled
    if (state_q == ACCESS && cnt_q == '0 && !we_q) begin
      if (grant_b_q) b_rdata_d = SRAM_DQ;
      else           a_rdata_d = SRAM_DQ;
    end
  end

  // Pin and ack outputs, decoded from the state being entered so that the
  // registered pins line up with the state they belong to
  always_comb begin
    ce_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_d != IDLE) begin
      ce_n_d  = 1'b0;
      ub_n_d  = be_n_d[1];
      lb_n_d  = be_n_d[0];
      dq_oe_d = we_d;
    end
    if (state_d == SETUP || state_d == ACCESS) oe_n_d = we_d;
    if (state_d == ACCESS)                     we_n_d = !we_d;
    if (state_d == DONE) begin
      a_ack_d = !grant_b_d;
      b_ack_d = grant_b_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      grant_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_n_q    <= '1;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      ce_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      grant_b_q <= grant_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_n_q    <= be_n_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      ce_n_q    <= ce_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;
  assign SRAM_ADDR = addr_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign oA_ACK    = a_ack_q;
  assign oB_ACK    = b_ack_q;
  assign oA_DATA   = a_rdata_q;
  assign oB_DATA   = b_rdata_q;
  assign oBUSY     = busy_q;

endmodule

// File: tb/tb_sram_arbiter_2port.sv
// Directed bench for sram_arbiter_2port with a behavioural async SRAM model.
// Optional build: SRAM_ARB_FIXED_PRIO_EN selects fixed-priority expectations.
module tb_sram_arbiter_2port;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [17:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [1:0]  a_be_n, b_be_n;
  logic        a_ack, b_ack, busy;
  logic [15:0] a_rdata, b_rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;
  logic [4:0]  strb;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:262143];

  always #5 clk = ~clk;

  sram_arbiter_2port #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .iCLK(clk), .iRST(rst),
    .iA_REQ(a_req), .iA_WE(a_we), .iA_ADDR(a_addr), .iA_DATA(a_data), .iA_BE_N(a_be_n),
    .oA_ACK(a_ack), .oA_DATA(a_rdata),
    .iB_REQ(b_req), .iB_WE(b_we), .iB_ADDR(b_addr), .iB_DATA(b_data), .iB_BE_N(b_be_n),
    .oB_ACK(b_ack), .oB_DATA(b_rdata),
    .oBUSY(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  // Behavioural SRAM: byte-lane writes while CE/WE low, drives DQ on reads
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  assign strb = {sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Strobe patterns {UB_N,LB_N,WE_N,CE_N,OE_N}
  localparam logic [4:0] S_IDLE  = 5'b11111;
  localparam logic [4:0] S_WSET  = 5'b00101;  // write SETUP / any DONE, both lanes
  localparam logic [4:0] S_WACC  = 5'b00001;
  localparam logic [4:0] S_RD    = 5'b00100;  // read SETUP/ACCESS
  localparam logic [4:0] S_LOWB  = 5'b10101;  // write SETUP, low lane only

  initial begin
    logic [1:0]  rr_ack  [4];
    logic [17:0] rr_addr [4];
`ifdef SRAM_ARB_FIXED_PRIO_EN
    rr_ack  = '{2'b10, 2'b10, 2'b10, 2'b10};
    rr_addr = '{18'h00100, 18'h00100, 18'h00100, 18'h00100};
`else
    rr_ack  = '{2'b10, 2'b01, 2'b10, 2'b01};
    rr_addr = '{18'h00100, 18'h00200, 18'h00100, 18'h00200};
`endif
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_data = '0; a_be_n = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_data = '0; b_be_n = '0;
    tick();
    tick();

    // Reset values
    chk("reset_strobes", strb, S_IDLE);
    chk("reset_addr", sram_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ack", {a_ack, b_ack}, 0);
    chk("reset_adata", a_rdata, 0);
    chk("reset_bdata", b_rdata, 0);
    chk("reset_dq_z", dut.dq_oe_q, 0);
    rst = 1'b0;

    // Both ports requesting from reset: grant order and ack routing
    a_req = 1; a_we = 1; a_addr = 18'h00100; a_data = 16'h1111;
    b_req = 1; b_we = 1; b_addr = 18'h00200; b_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); tick(); tick();
      chk("rr_ack", {a_ack, b_ack}, rr_ack[k]);
      chk("rr_addr", sram_addr, rr_addr[k]);
      if (k < 3) tick();
    end
`ifdef SRAM_ARB_FIXED_PRIO_EN
    // A drops: B is served on the very next IDLE
    a_req = 0;
    tick();
    tick(); tick(); tick(); tick();
    chk("fixed_b_after_a", {a_ack, b_ack}, 2'b01);
    chk("fixed_b_addr", sram_addr, 18'h00200);
`endif
    a_req = 0; b_req = 0;
    tick();
    chk("rr_idle_busy", busy, 0);
    chk("rr_idle_ack", {a_ack, b_ack}, 0);

    // Port A word write 0xBEEF to 0x00012
    a_req = 1; a_we = 1; a_addr = 18'h00012; a_data = 16'hBEEF; a_be_n = 2'b00;
    tick();
    chk("w_setup_strb", strb, S_WSET);
    chk("w_setup_dq", sram_dq, 16'hBEEF);
    chk("w_setup_addr", sram_addr, 18'h00012);
    chk("w_setup_busy", busy, 1);
    tick();
    chk("w_acc1_strb", strb, S_WACC);
    chk("w_acc1_dq", sram_dq, 16'hBEEF);
    tick();
    chk("w_acc2_strb", strb, S_WACC);
    chk("w_acc2_ack", {a_ack, b_ack}, 0);
    tick();
    chk("w_done_strb", strb, S_WSET);
    chk("w_done_dq", sram_dq, 16'hBEEF);
    chk("w_done_ack", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    tick();
    chk("w_idle_strb", strb, S_IDLE);
    chk("w_idle_ack", {a_ack, b_ack}, 0);
    chk("w_idle_dq_z", dut.dq_oe_q, 0);
    chk("w_idle_busy", busy, 0);

    // Port A read back of 0x00012
    a_req = 1; a_we = 0;
    tick();
    chk("r_setup_strb", strb, S_RD);
    chk("r_setup_dq_z", dut.dq_oe_q, 0);
    tick();
    chk("r_acc1_strb", strb, S_RD);
    tick();
    chk("r_acc2_strb", strb, S_RD);
    tick();
    chk("r_done_strb", strb, S_WSET);
    chk("r_done_ack", {a_ack, b_ack}, 2'b10);
    chk("r_done_data", a_rdata, 16'hBEEF);
    chk("r_done_bdata", b_rdata, 0);
    a_req = 0;
    tick();
    chk("r_hold_data", a_rdata, 16'hBEEF);
    chk("r_hold_ack", {a_ack, b_ack}, 0);

    // Port B: full word, then low-byte write at top address, then read back
    b_req = 1; b_we = 1; b_addr = 18'h3FFFF; b_data = 16'hA5C3; b_be_n = 2'b00;
    tick(); tick(); tick(); tick();
    chk("bw_full_ack", {a_ack, b_ack}, 2'b01);
    b_data = 16'h1234; b_be_n = 2'b10;
    tick();
    chk("bw_byte_idle_ack", {a_ack, b_ack}, 0);
    tick();
    chk("bw_byte_strb", strb, S_LOWB);
    chk("bw_byte_addr", sram_addr, 18'h3FFFF);
    chk("bw_byte_dq", sram_dq, 16'h1234);
    tick(); tick(); tick();
    chk("bw_byte_ack", {a_ack, b_ack}, 2'b01);
    b_we = 0; b_be_n = 2'b00;
    tick();
    tick(); tick(); tick(); tick();
    chk("br_ack", {a_ack, b_ack}, 2'b01);
    chk("br_data", b_rdata, 16'hA534);
    chk("br_adata_kept", a_rdata, 16'hBEEF);
    b_req = 0;
    tick();

    // Reset during ACCESS of a write, then a normal access
    a_req = 1; a_we = 1; a_addr = 18'h00040; a_data = 16'h5555; a_be_n = 2'b00;
    tick(); tick();
    chk("abort_acc_strb", strb, S_WACC);
    rst = 1;
    tick();
    chk("abort_strb", strb, S_IDLE);
    chk("abort_dq_z", dut.dq_oe_q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {a_ack, b_ack}, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_adata", a_rdata, 0);
    rst = 0; a_req = 0;
    tick();
    chk("abort_no_ack", {a_ack, b_ack}, 0);
    a_req = 1; a_we = 0; a_addr = 18'h00012;
    tick(); tick(); tick(); tick();
    chk("post_abort_ack", {a_ack, b_ack}, 2'b10);
    chk("post_abort_data", a_rdata, 16'hBEEF);
    a_req = 0;
    tick();
    chk("post_abort_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
